// File: rtl/r200_lsu_pkg.sv
// r200 load/store unit shared definitions.
// Holds the RV32I func3 encodings for loads/stores, the access-size field
// decode, and the MEM-stage FSM state type.
package r200_lsu_pkg;

   // func3 encodings (loads and stores share the low size bits)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access size, taken from func3[1:0]; SZ_RSVD is always treated as misaligned
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      return lsu_size_e'(f3[1:0]);
   endfunction

   // func3[2] selects zero extension for LBU/LHU
   function automatic logic f3_is_unsigned(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for the r200 load/store unit.
// Store path : i_st_addr_lo, i_st_func3, i_wdata -> o_wstrb, o_wdata, o_misalign
// Load path  : i_ld_addr_lo, i_ld_func3, i_bus_rdata -> o_rdata (lane-selected, extended)
module lsu_align
   import r200_lsu_pkg::*;
(
   input  logic [1:0]  i_st_addr_lo,
   input  logic [2:0]  i_st_func3,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic        o_misalign,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [2:0]  i_ld_func3,
   input  logic [31:0] i_bus_rdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sext;

   // Store lanes and alignment check
   always_comb begin
      o_wstrb    = 4'b0000;
      o_wdata    = i_wdata;
      o_misalign = 1'b0;
      unique case (f3_size(i_st_func3))
         SZ_BYTE: begin
            o_wdata = {4{i_wdata[7:0]}};
            o_wstrb = 4'b0001 << i_st_addr_lo;
         end
         SZ_HALF: begin
            o_wdata    = {2{i_wdata[15:0]}};
            o_wstrb    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_misalign = i_st_addr_lo[0];
         end
         SZ_WORD: begin
            o_wstrb    = 4'b1111;
            o_misalign = |i_st_addr_lo;
         end
         default: begin
            o_misalign = 1'b1;
         end
      endcase
   end

   // Load lane select and extension
   always_comb begin
      w_byte = i_bus_rdata[7:0];
      unique case (i_ld_addr_lo)
         2'd0:    w_byte = i_bus_rdata[7:0];
         2'd1:    w_byte = i_bus_rdata[15:8];
         2'd2:    w_byte = i_bus_rdata[23:16];
         default: w_byte = i_bus_rdata[31:24];
      endcase
      w_half = i_ld_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
      w_sext = ~f3_is_unsigned(i_ld_func3);

      unique case (f3_size(i_ld_func3))
         SZ_BYTE: o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
         SZ_HALF: o_rdata = {{16{w_sext & w_half[15]}}, w_half};
         default: o_rdata = i_bus_rdata;
      endcase
   end

endmodule

// File: rtl/r200lsu.sv
// r200 MEM-stage load/store unit.
// Accepts one load/store per instruction, drives a word-wide req/ack data bus,
// stalls the pipeline while the access is outstanding and abandons it after
// TIMEOUT_CYCLES BUSY cycles without an ack.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid, i_memrd, i_memwr, i_func3, i_addr, i_wdata   EX/MEM request
//   o_stall               pipeline hold / MEM-WB bubble
//   o_ld_valid, o_rdata   completion pulse and aligned, extended load data
//   o_misalign, o_bus_err one-cycle error pulses (coincide with o_ld_valid)
//   o_bus_*, i_bus_*      data-memory bus
module r200lsu
   import r200_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned AW             = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req_valid,
   input  logic          i_memrd,
   input  logic          i_memwr,
   input  logic [2:0]    i_func3,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic          o_stall,
   output logic          o_ld_valid,
   output logic [31:0]   o_rdata,
   output logic          o_misalign,
   output logic          o_bus_err,
   output logic          o_bus_req,
   output logic          o_bus_we,
   output logic [AW-1:0] o_bus_addr,
   output logic [3:0]    o_bus_wstrb,
   output logic [31:0]   o_bus_wdata,
   input  logic          i_bus_ack,
   input  logic [31:0]   i_bus_rdata
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e    r_state, w_state_next;
   logic [TW-1:0] r_tmo;
   logic          r_misalign;
   logic          r_bus_err;
   logic          r_is_store;
   logic [1:0]    r_ld_addr_lo;
   logic [2:0]    r_ld_func3;
   logic [31:0]   r_rdata;
   logic          r_bus_req;
   logic          r_bus_we;
   logic [AW-1:0] r_bus_addr;
   logic [3:0]    r_bus_wstrb;
   logic [31:0]   r_bus_wdata;

   logic          w_access;
   logic          w_misalign;
   logic [3:0]    w_wstrb;
   logic [31:0]   w_wdata;
   logic [31:0]   w_ld_data;
   logic          w_ack;
   logic          w_timeout;

   lsu_align u_align (
      .i_st_addr_lo (i_addr[1:0]),
      .i_st_func3   (i_func3),
      .i_wdata      (i_wdata),
      .o_wstrb      (w_wstrb),
      .o_wdata      (w_wdata),
      .o_misalign   (w_misalign),
      .i_ld_addr_lo (r_ld_addr_lo),
      .i_ld_func3   (r_ld_func3),
      .i_bus_rdata  (i_bus_rdata),
      .o_rdata      (w_ld_data)
   );

   assign w_access  = (r_state == IDLE) & i_req_valid & (i_memrd | i_memwr);
   assign w_ack     = (r_state == BUSY) & r_bus_req & i_bus_ack;
   // Last permitted BUSY cycle with no ack; ack in that same cycle still wins
   assign w_timeout = (r_state == BUSY) & ~w_ack & (r_tmo == TW'(TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_access) begin
               w_state_next = w_misalign ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (w_ack || w_timeout) begin
               w_state_next = DONE;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs; stall is forced low during reset so every output clears at once
   always_comb begin
      o_stall     = i_rst_n & (((r_state == IDLE) & w_access & ~w_misalign) |
                               (r_state == BUSY));
      o_ld_valid  = (r_state == DONE);
      o_misalign  = (r_state == DONE) & r_misalign;
      o_bus_err   = (r_state == DONE) & r_bus_err;
      o_rdata     = r_rdata;
      o_bus_req   = r_bus_req;
      o_bus_we    = r_bus_we;
      o_bus_addr  = r_bus_addr;
      o_bus_wstrb = r_bus_wstrb;
      o_bus_wdata = r_bus_wdata;
   end

   // Datapath: bus registers, timeout counter, result capture
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmo        <= '0;
         r_misalign   <= 1'b0;
         r_bus_err    <= 1'b0;
         r_is_store   <= 1'b0;
         r_ld_addr_lo <= 2'b00;
         r_ld_func3   <= 3'b000;
         r_rdata      <= 32'h0;
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wstrb  <= 4'b0000;
         r_bus_wdata  <= 32'h0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_access) begin
                  r_tmo        <= '0;
                  r_bus_err    <= 1'b0;
                  r_misalign   <= w_misalign;
                  r_is_store   <= i_memwr;
                  r_ld_addr_lo <= i_addr[1:0];
                  r_ld_func3   <= i_func3;
                  if (w_misalign) begin
                     r_rdata <= 32'h0;
                  end else begin
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= i_memwr;
                     r_bus_addr  <= {i_addr[AW-1:2], 2'b00};
                     r_bus_wstrb <= i_memwr ? w_wstrb : 4'b0000;
                     r_bus_wdata <= i_memwr ? w_wdata : 32'h0;
                  end
               end
            end
            BUSY: begin
               if (w_ack || w_timeout) begin
                  // Stores and timeouts report zero data
                  r_rdata     <= (w_ack && !r_is_store) ? w_ld_data : 32'h0;
                  r_bus_err   <= w_timeout;
                  r_bus_req   <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_addr  <= '0;
                  r_bus_wstrb <= 4'b0000;
                  r_bus_wdata <= 32'h0;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_r200lsu.sv
module tb_r200lsu;
   import r200_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req_valid, i_memrd, i_memwr;
   logic [2:0]  i_func3;
   logic [31:0] i_addr, i_wdata;
   logic        o_stall, o_ld_valid, o_misalign, o_bus_err;
   logic [31:0] o_rdata;
   logic        o_bus_req, o_bus_we;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_wstrb;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   r200lsu #(.TIMEOUT_CYCLES(4), .AW(32)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (i_req_valid),
      .i_memrd     (i_memrd),
      .i_memwr     (i_memwr),
      .i_func3     (i_func3),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_stall     (o_stall),
      .o_ld_valid  (o_ld_valid),
      .o_rdata     (o_rdata),
      .o_misalign  (o_misalign),
      .o_bus_err   (o_bus_err),
      .o_bus_req   (o_bus_req),
      .o_bus_we    (o_bus_we),
      .o_bus_addr  (o_bus_addr),
      .o_bus_wstrb (o_bus_wstrb),
      .o_bus_wdata (o_bus_wdata),
      .i_bus_ack   (i_bus_ack),
      .i_bus_rdata (i_bus_rdata)
   );

   typedef struct {
      logic        memrd;
      logic        memwr;
      logic [2:0]  func3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brdata;
      int          ack_delay;  // ack in the Nth bus_req cycle; 0 = never
      logic [31:0] e_addr;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      int          e_stall;
      int          e_req;
      logic        e_mis;
      logic        e_err;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          req_cyc = 0;
      int          stall_cyc = 0;
      bit          seen = 0;
      bit          done = 0;
      logic        got_we = 0;
      logic [31:0] got_addr = 0, got_wdata = 0, got_rdata = 0;
      logic [3:0]  got_wstrb = 0;
      logic        got_mis = 0, got_err = 0;
      @(posedge clk); #1;
      i_req_valid = 1'b1;
      i_memrd     = v.memrd;
      i_memwr     = v.memwr;
      i_func3     = v.func3;
      i_addr      = v.addr;
      i_wdata     = v.wdata;
      i_bus_rdata = v.brdata;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_stall) stall_cyc++;
         if (o_bus_req) begin
            if (!seen) begin
               got_we    = o_bus_we;
               got_addr  = o_bus_addr;
               got_wstrb = o_bus_wstrb;
               got_wdata = o_bus_wdata;
            end
            seen = 1;
            req_cyc++;
            i_bus_ack = (v.ack_delay != 0) && (req_cyc == v.ack_delay);
         end
         if (o_ld_valid || o_misalign) begin
            done      = 1;
            got_rdata = o_rdata;
            got_mis   = o_misalign;
            got_err   = o_bus_err;
         end
         @(posedge clk); #1;
         i_bus_ack = 1'b0;
         if (done) break;
      end
      i_req_valid = 1'b0;
      i_memrd     = 1'b0;
      i_memwr     = 1'b0;
      check($sformatf("v%0d completed", idx), 32'(done), 32'd1);
      check($sformatf("v%0d stall_cycles", idx), stall_cyc, v.e_stall);
      check($sformatf("v%0d req_cycles", idx), req_cyc, v.e_req);
      check($sformatf("v%0d misalign", idx), 32'(got_mis), 32'(v.e_mis));
      check($sformatf("v%0d bus_err", idx), 32'(got_err), 32'(v.e_err));
      check($sformatf("v%0d rdata", idx), got_rdata, v.e_rdata);
      if (v.e_req != 0) begin
         check($sformatf("v%0d bus_we", idx), 32'(got_we), 32'(v.memwr));
         check($sformatf("v%0d bus_addr", idx), got_addr, v.e_addr);
         check($sformatf("v%0d bus_wstrb", idx), 32'(got_wstrb), 32'(v.e_wstrb));
         if (v.memwr) check($sformatf("v%0d bus_wdata", idx), got_wdata, v.e_wdata);
      end
      @(negedge clk);
      check($sformatf("v%0d ld_valid_one_cycle", idx), 32'(o_ld_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //         rd wr func3   addr      wdata         brdata     dly e_addr  strb     e_wdata       e_rdata     st rq mis err
      vecs[0]  = '{1, 0, F3_LB,  32'h103, 32'h0,        32'h80FF1234, 1, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 2, 1, 0, 0};
      vecs[1]  = '{1, 0, F3_LHU, 32'h102, 32'h0,        32'hBEEF0000, 2, 32'h100, 4'b0000, 32'h0,        32'h0000BEEF, 3, 2, 0, 0};
      vecs[2]  = '{1, 0, F3_LH,  32'h102, 32'h0,        32'hBEEF0000, 1, 32'h100, 4'b0000, 32'h0,        32'hFFFFBEEF, 2, 1, 0, 0};
      vecs[3]  = '{0, 1, F3_SB,  32'h201, 32'h000000A5, 32'h12345678, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0,        2, 1, 0, 0};
      vecs[4]  = '{0, 1, F3_SH,  32'h202, 32'h00001234, 32'h0,        3, 32'h200, 4'b1100, 32'h12341234, 32'h0,        4, 3, 0, 0};
      vecs[5]  = '{1, 0, F3_LW,  32'h302, 32'h0,        32'hFFFFFFFF, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 0, 1, 0};
      vecs[6]  = '{1, 0, F3_LBU, 32'h101, 32'h0,        32'h00009A00, 1, 32'h100, 4'b0000, 32'h0,        32'h0000009A, 2, 1, 0, 0};
      vecs[7]  = '{0, 1, F3_SW,  32'h040, 32'hDEADBEEF, 32'h0,        1, 32'h040, 4'b1111, 32'hDEADBEEF, 32'h0,        2, 1, 0, 0};
      vecs[8]  = '{1, 0, F3_LH,  32'h101, 32'h0,        32'h12345678, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 0, 1, 0};
      vecs[9]  = '{1, 0, F3_LW,  32'h010, 32'h0,        32'hCAFEF00D, 1, 32'h010, 4'b0000, 32'h0,        32'hCAFEF00D, 2, 1, 0, 0};
      vecs[10] = '{1, 0, F3_LW,  32'h020, 32'h0,        32'h11111111, 0, 32'h020, 4'b0000, 32'h0,        32'h0,        5, 4, 0, 1};
      vecs[11] = '{1, 1, F3_SB,  32'h003, 32'h0000007F, 32'h0,        1, 32'h000, 4'b1000, 32'h7F7F7F7F, 32'h0,        2, 1, 0, 0};
      vecs[12] = '{1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 0, 1, 0};
      vecs[13] = '{1, 0, F3_LH,  32'h100, 32'h0,        32'h80007FFF, 1, 32'h100, 4'b0000, 32'h0,        32'h00007FFF, 2, 1, 0, 0};
      vecs[14] = '{0, 1, F3_SH,  32'h050, 32'hABCD5678, 32'h0,        2, 32'h050, 4'b0011, 32'h56785678, 32'h0,        3, 2, 0, 0};

      rst_n       = 1'b0;
      i_req_valid = 1'b0;
      i_memrd     = 1'b0;
      i_memwr     = 1'b0;
      i_func3     = 3'b000;
      i_addr      = 32'h0;
      i_wdata     = 32'h0;
      i_bus_ack   = 1'b0;
      i_bus_rdata = 32'h0;
      #1;
      check("reset stall", 32'(o_stall), 32'd0);
      check("reset ld_valid", 32'(o_ld_valid), 32'd0);
      check("reset rdata", o_rdata, 32'd0);
      check("reset err_flags", {30'd0, o_misalign, o_bus_err}, 32'd0);
      check("reset bus_req_we", {30'd0, o_bus_req, o_bus_we}, 32'd0);
      check("reset bus_addr", o_bus_addr, 32'd0);
      check("reset bus_wstrb", 32'(o_bus_wstrb), 32'd0);
      check("reset bus_wdata", o_bus_wdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Stray ack while IDLE must not start or complete anything
      @(posedge clk); #1;
      i_bus_ack = 1'b1;
      @(posedge clk); #1;
      i_bus_ack = 1'b0;
      @(negedge clk);
      check("idle_ack ld_valid", 32'(o_ld_valid), 32'd0);
      check("idle_ack stall", 32'(o_stall), 32'd0);

      // Reset in the second BUSY cycle of a load that is never acknowledged
      @(posedge clk); #1;
      i_req_valid = 1'b1;
      i_memrd     = 1'b1;
      i_func3     = F3_LW;
      i_addr      = 32'h80;
      @(negedge clk);               // accept
      @(negedge clk);               // BUSY 1
      @(posedge clk); #2;           // BUSY 2
      check("midrst pre stall", 32'(o_stall), 32'd1);
      check("midrst pre bus_req", 32'(o_bus_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst bus_req", 32'(o_bus_req), 32'd0);
      check("midrst stall", 32'(o_stall), 32'd0);
      check("midrst ld_valid", 32'(o_ld_valid), 32'd0);
      i_req_valid = 1'b0;
      i_memrd     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(100, vecs[9]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
